// File: rtl/alu_iter.sv
// Handshaked multi-cycle ALU: single-cycle logic/arith ops, iterative one-bit-per-cycle shifts.
// Op-code encoding mirrors the team alu_defines.v set.

package alu_iter_pkg;

  typedef enum logic [3:0] {
    OP_SLL = 4'b0001,
    OP_SRL = 4'b0010,
    OP_SRA = 4'b0011,
    OP_AND = 4'b1000,
    OP_OR  = 4'b1001,
    OP_XOR = 4'b1010,
    OP_NOR = 4'b1011,
    OP_ADD = 4'b1100,
    OP_SUB = 4'b1101,
    OP_SLT = 4'b1111
  } alu_op_e;

  typedef enum logic [1:0] {
    SK_SLL,
    SK_SRL,
    SK_SRA
  } shift_kind_e;

endpackage

module alu_iter
  import alu_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstb,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  input  logic [3:0]       op_code,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Z,
  output logic             equal,
  output logic             overflow,
  output logic             zero
);

  localparam int SHW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_e;

  state_e           state;
  logic [WIDTH-1:0] work;
  logic [SHW-1:0]   cnt;
  shift_kind_e      shift_kind;

  logic [WIDTH-1:0] b_eff;
  logic [WIDTH-1:0] sum;
  logic [WIDTH-1:0] alu_z;
  logic             alu_ovf;
  logic             valid_op;
  logic             is_shift;
  logic             shift_sat;
  logic [SHW-1:0]   shift_amt;
  logic             shift_iter;
  shift_kind_e      kind_next;
  logic [WIDTH-1:0] work_next;

  assign shift_sat  = |Y[WIDTH-1:SHW];
  assign shift_amt  = Y[SHW-1:0];
  assign shift_iter = is_shift && !shift_sat && (shift_amt != '0);

  // Result for every op that finishes on the accept edge; iterative shifts
  // only need the kind decoded here.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    b_eff     = (op_code == OP_SUB) ? (~Y + 1'b1) : Y;
    sum       = X + b_eff;
    alu_z     = '0;
    alu_ovf   = 1'b0;
    valid_op  = 1'b1;
    is_shift  = 1'b0;
    kind_next = SK_SLL;
    case (op_code)
      OP_AND: alu_z = X & Y;
      OP_OR:  alu_z = X | Y;
      OP_XOR: alu_z = X ^ Y;
      OP_NOR: alu_z = ~(X | Y);
      OP_ADD, OP_SUB: begin
        alu_z   = sum;
        alu_ovf = (X[WIDTH-1] == b_eff[WIDTH-1]) && (sum[WIDTH-1] != X[WIDTH-1]);
      end
      OP_SLT: alu_z = {{(WIDTH-1){1'b0}}, ($signed(X) < $signed(Y))};
      OP_SLL: begin
        is_shift  = 1'b1;
        kind_next = SK_SLL;
        alu_z     = shift_sat ? '0 : X;
      end
      OP_SRL: begin
        is_shift  = 1'b1;
        kind_next = SK_SRL;
        alu_z     = shift_sat ? '0 : X;
      end
      OP_SRA: begin
        is_shift  = 1'b1;
        kind_next = SK_SRA;
        alu_z     = shift_sat ? {WIDTH{X[WIDTH-1]}} : X;
      end
      default: valid_op = 1'b0;
    endcase
  end

  always_comb begin
    case (shift_kind)
      SK_SLL:  work_next = {work[WIDTH-2:0], 1'b0};
      SK_SRL:  work_next = {1'b0, work[WIDTH-1:1]};
      default: work_next = {work[WIDTH-1], work[WIDTH-1:1]};
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state      <= S_IDLE;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      Z          <= '0;
      equal      <= 1'b0;
      overflow   <= 1'b0;
      zero       <= 1'b0;
      // NOTE: the shift datapath is reset too so an aborted shift leaves no stale state.
      work       <= '0;
      cnt        <= '0;
      shift_kind <= SK_SLL;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            equal    <= valid_op && (X == Y);
            overflow <= alu_ovf;
            if (shift_iter) begin
              work       <= X;
              cnt        <= shift_amt;
              shift_kind <= kind_next;
              state      <= S_SHIFT;
            end else begin
              Z         <= alu_z;
              zero      <= valid_op && (alu_z == '0);
              out_valid <= 1'b1;
              state     <= S_DONE;
            end
          end
        end
        S_SHIFT: begin
          work <= work_next;
          cnt  <= cnt - 1'b1;
          // The last shift lands directly in Z so DONE follows without a spare cycle.
          if (cnt == SHW'(1)) begin
            Z         <= work_next;
            zero      <= (work_next == '0);
            out_valid <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= S_IDLE;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Directed self-checking bench for alu_iter: hand-computed results, flags and latencies.

module tb_alu_iter;
  import alu_iter_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             rstb;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic [3:0]       op_code;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Z;
  logic             equal;
  logic             overflow;
  logic             zero;

  int checks = 0;
  int errors = 0;

  alu_iter #(.WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rstb      (rstb),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .X         (X),
    .Y         (Y),
    .op_code   (op_code),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .Z         (Z),
    .equal     (equal),
    .overflow  (overflow),
    .zero      (zero)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue one request with out_ready high, measure accept-to-out_valid latency,
  // check result and flags, then confirm the handshake returns to idle.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                        input logic [31:0] b, input int exp_lat, input logic [31:0] exp_z,
                        input logic exp_eq, input logic exp_ovf, input logic exp_zero);
    int lat;
    out_ready = 1'b1;
    op_code   = op;
    X         = a;
    Y         = b;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    X        = ~a;
    Y        = a;
    op_code  = 4'b0000;
    lat      = 1;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    check({tag, ".lat"}, 32'(lat), 32'(exp_lat));
    check({tag, ".z"}, Z, exp_z);
    check({tag, ".flags"}, {29'd0, equal, overflow, zero}, {29'd0, exp_eq, exp_ovf, exp_zero});
    tick();
    check({tag, ".idle"}, {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
  endtask

  initial begin
    rstb      = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    X         = '0;
    Y         = '0;
    op_code   = 4'b0000;
    repeat (3) tick();
    check("reset.handshake", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    check("reset.z", Z, 32'h0);
    check("reset.flags", {29'd0, equal, overflow, zero}, 32'h0);
    rstb = 1'b1;
    tick();

    run_op("add_small", OP_ADD, 32'd34, 32'd36, 1, 32'd70, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf", OP_ADD, 32'h6FFFFFEE, 32'h6FF7FFFE, 1, 32'hDFF7FFEC, 1'b0, 1'b1, 1'b0);
    run_op("sub_ovf", OP_SUB, 32'h6FFFFFEE, 32'h8FF7FFFE, 1, 32'hE007FFF0, 1'b0, 1'b1, 1'b0);
    run_op("slt_ovf_pair", OP_SLT, 32'h6FFFFFEE, 32'h8FF7FFFE, 1, 32'h0, 1'b0, 1'b0, 1'b1);
    run_op("slt_neg_pos", OP_SLT, 32'hFFFFFFFF, 32'h00000001, 1, 32'h1, 1'b0, 1'b0, 1'b0);
    run_op("reserved", 4'b0000, 32'd1, 32'd1, 1, 32'h0, 1'b0, 1'b0, 1'b0);
    run_op("nor", OP_NOR, 32'h0F0F0000, 32'h00F0F000, 1, 32'hF0000FFF, 1'b0, 1'b0, 1'b0);
    run_op("xor_eq", OP_XOR, 32'h12345678, 32'h12345678, 1, 32'h0, 1'b1, 1'b0, 1'b1);
    run_op("srl_sat", OP_SRL, 32'h80000010, 32'd40, 1, 32'h0, 1'b0, 1'b0, 1'b1);
    run_op("sra_sat", OP_SRA, 32'h80000010, 32'd40, 1, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0);
    run_op("sll_zero_amt", OP_SLL, 32'hA5A5A5A5, 32'd0, 1, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
    run_op("sra_4", OP_SRA, 32'h80000010, 32'd4, 5, 32'hF8000001, 1'b0, 1'b0, 1'b0);
    run_op("srl_31", OP_SRL, 32'h80000010, 32'd31, 32, 32'h1, 1'b0, 1'b0, 1'b0);
    run_op("sll_3", OP_SLL, 32'h30000001, 32'd3, 4, 32'h80000008, 1'b0, 1'b0, 1'b0);

    // Result held under back-pressure; new requests during the stall are dropped.
    out_ready = 1'b0;
    op_code   = OP_SUB;
    X         = 32'd1;
    Y         = 32'd1;
    in_valid  = 1'b1;
    tick();
    for (int i = 0; i < 6; i++) begin
      op_code  = OP_ADD;
      X        = 32'd5 + 32'(i);
      Y        = 32'd9;
      in_valid = (i % 2) == 0;
      tick();
      check("stall.hold", {Z[27:0], in_ready, out_valid, equal, zero},
            {28'd0, 1'b0, 1'b1, 1'b1, 1'b1});
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("stall.release", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    tick();
    check("stall.no_queue", {31'd0, out_valid}, 32'h0);

    // Asynchronous reset in the middle of a long shift.
    run_op("sra_prev", OP_SRA, 32'h80000010, 32'd4, 5, 32'hF8000001, 1'b0, 1'b0, 1'b0);
    op_code  = OP_SLL;
    X        = 32'd1;
    Y        = 32'd20;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    check("shift.busy", {30'd0, in_ready, out_valid}, {30'd0, 1'b0, 1'b0});
    #2;
    rstb = 1'b0;
    #1;
    check("async_rst.z", Z, 32'h0);
    check("async_rst.handshake", {30'd0, in_ready, out_valid}, {30'd0, 1'b1, 1'b0});
    check("async_rst.flags", {29'd0, equal, overflow, zero}, 32'h0);
    tick();
    rstb = 1'b1;
    tick();
    check("after_rst.quiet", {31'd0, out_valid}, 32'h0);
    run_op("and_after_rst", OP_AND, 32'd6, 32'd3, 1, 32'd2, 1'b0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
